imm_extend_pipe: RTL

Registered, parametrised immediate generator for the MIPS datapath. It extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI) or branch (sign-extend then shift left 2). The result passes through a valid/ready pipeline stage with a one-entry skid buffer, so decode can stall without losing immediates. It sits between decode and the ALU-operand/branch-target logic.

---
 rtl/imm_extend_pipe_pkg.sv | 14 +
 rtl/imm_ext_core.sv | 35 +++
 rtl/imm_extend_pipe.sv | 84 ++++++++
 3 files changed

// File: rtl/imm_extend_pipe_pkg.sv
// Shared immediate-extension constants: mode encodings reused by decoder,
// control unit and the immediate generator.
package imm_extend_pipe_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_e;

endpackage : imm_extend_pipe_pkg

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: (imm, mode) -> OUT_W-bit value.
module imm_ext_core
  import imm_extend_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic [IN_W-1:0]   i_imm,
  input  logic [MODE_W-1:0] i_mode,
  output logic [OUT_W-1:0]  o_ext
);

  logic [OUT_W-1:0] w_sign;
  logic [OUT_W-1:0] w_zero;
  logic [OUT_W-1:0] w_upper;
  logic [OUT_W-1:0] w_branch;

  assign w_sign   = {{(OUT_W-IN_W){i_imm[IN_W-1]}}, i_imm};
  assign w_zero   = {{(OUT_W-IN_W){1'b0}}, i_imm};
  assign w_upper  = OUT_W'({i_imm, {IN_W{1'b0}}});
  // Branch offset is a word offset: sign-extend, then scale by 4.
  assign w_branch = {w_sign[OUT_W-3:0], 2'b00};

  always_comb begin
    o_ext = w_sign;
    case (i_mode)
      MODE_SIGN:   o_ext = w_sign;
      MODE_ZERO:   o_ext = w_zero;
      MODE_UPPER:  o_ext = w_upper;
      MODE_BRANCH: o_ext = w_branch;
      default:     o_ext = w_sign;
    endcase
  end

endmodule : imm_ext_core

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator: extender followed by a valid/ready
// output register with a one-entry skid buffer.
module imm_extend_pipe
  import imm_extend_pipe_pkg::*;
#(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_imm,
  input  logic [MODE_W-1:0] in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  if (OUT_W < 2*IN_W) begin : g_bad_width
    $error("imm_extend_pipe: OUT_W must be at least 2*IN_W");
  end

  logic [OUT_W-1:0] w_ext;
  logic             w_in_fire;
  logic             w_out_free;

  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_skid_valid;
  logic [OUT_W-1:0] r_skid_data;
  logic [TAG_W-1:0] r_skid_tag;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .i_imm  (in_imm),
    .i_mode (in_mode),
    .o_ext  (w_ext)
  );

  // Ready comes from registered state only, so out_ready never reaches in_ready.
  assign in_ready   = ~r_skid_valid & ~reset;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_free = ~r_out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_tag    <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_tag   <= '0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_data   <= r_skid_data;
        r_out_tag    <= r_skid_tag;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_ext;
        r_out_tag   <= in_tag;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_ext;
      r_skid_tag   <= in_tag;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;

endmodule : imm_extend_pipe
